// File: rtl/sudoku_io_port.sv
// Solver-side bus responder: requests a puzzle, feeds the solver core, drives the result back.
// Optional macro SUDOKU_IO_CHECK_EN adds result validation and a sticky check_fail output.
module sudoku_io_port #(
    parameter int LOAD_LAT     = 2,
    parameter int DRIVE_CYCLES = 3,
    parameter int MAX_CYCLES   = 100000,
    parameter int NUM_PUZZLES  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [323:0] puz_in,
    output logic [323:0] puz_out,
    output logic         puzzle_oe,
    output logic         next_puzzle,
    output logic         solution,
    output logic         give_up,
    output logic         core_start,
    output logic         core_abort,
    output logic [323:0] core_puzzle,
    input  logic         core_done,
    input  logic         core_solved,
    input  logic [323:0] core_grid,
`ifdef SUDOKU_IO_CHECK_EN
    output logic         check_fail,
`endif
    output logic [9:0]   puzzles_done,
    output logic         halted
);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, SOLVE, DRIVE, HALT} state_t;

    state_t      state, next_state;
    logic [31:0] cnt;
    logic        load_last, drive_last, timeout, flag;

`ifdef SUDOKU_IO_CHECK_EN
    function automatic logic grid_ok(input logic [323:0] g, input logic [323:0] p);
        logic ok;
        ok = 1'b1;
        for (int unsigned k = 0; k < 81; k++) begin
            if (g[4*k +: 4] == 4'd0 || g[4*k +: 4] > 4'd9) ok = 1'b0;
            if (p[4*k +: 4] != 4'd0 && p[4*k +: 4] != g[4*k +: 4]) ok = 1'b0;
        end
        return ok;
    endfunction
`endif

    // cnt counts cycles since entry into the current state
    always_comb begin
        load_last  = (cnt == 32'(LOAD_LAT - 1));
        drive_last = (cnt == 32'(DRIVE_CYCLES - 1));
        timeout    = (MAX_CYCLES != 0) && (cnt == 32'(MAX_CYCLES - 1));
`ifdef SUDOKU_IO_CHECK_EN
        flag       = core_solved && grid_ok(core_grid, core_puzzle);
`else
        flag       = core_solved;
`endif
        next_state = state;
        core_abort = 1'b0;
        case (state)
            IDLE:  next_state = REQ;
            REQ:   next_state = LOAD;
            LOAD:  if (load_last) next_state = START;
            START: next_state = SOLVE;
            SOLVE: begin
                if (core_done) begin
                    next_state = DRIVE;
                end else if (timeout) begin
                    next_state = DRIVE;
                    core_abort = 1'b1;
                end
            end
            DRIVE: begin
                if (drive_last) begin
                    if (NUM_PUZZLES != 0 && (puzzles_done + 10'd1) == 10'(NUM_PUZZLES))
                        next_state = HALT;
                    else
                        next_state = REQ;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    assign puzzle_oe  = (state == DRIVE);
    assign core_start = (state == START);
    assign halted     = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            next_puzzle  <= 1'b0;
            solution     <= 1'b0;
            give_up      <= 1'b0;
            puz_out      <= '0;
            core_puzzle  <= '0;
            puzzles_done <= '0;
`ifdef SUDOKU_IO_CHECK_EN
            check_fail   <= 1'b0;
`endif
        end else begin
            state       <= next_state;
            cnt         <= (next_state != state) ? '0 : cnt + 32'd1;
            next_puzzle <= (next_state == REQ);
            solution    <= (state == SOLVE) && core_done && flag;
            give_up     <= (state == SOLVE) && (next_state == DRIVE) && !(core_done && flag);
            if (state == LOAD && load_last)
                core_puzzle <= puz_in;
            if (state == SOLVE) begin
                if (core_done)
                    puz_out <= core_grid;
                else if (timeout)
                    puz_out <= core_puzzle;
            end
            if (state == DRIVE && drive_last)
                puzzles_done <= puzzles_done + 10'd1;
`ifdef SUDOKU_IO_CHECK_EN
            if (state == SOLVE && core_done && core_solved && !flag)
                check_fail <= 1'b1;
`endif
        end
    end

endmodule
